// File: rtl/enviar_hora_if.sv
// enviar_hora_if: byte-wide valid/ready link between the frame
// transmitter and the UART transmitter that consumes its bytes.
interface enviar_hora_if;
    logic [7:0] dato;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output dato,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  dato,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/enviar_hora.sv
// enviar_hora: serialises a six-digit ASCII time into a
// z D0..D5 z byte frame, idling a fixed gap after each byte.
module enviar_hora #(
    parameter int unsigned GAP_CYCLES = 50_000,
    parameter logic [7:0]  MARK       = 8'd122
) (
    input  logic          clk,
    input  logic          init,
    input  logic          start,
    input  logic [47:0]   hora,
    enviar_hora_if.master tx,
    output logic          busy,
    output logic          DONE,
    output logic          ERR
);
    localparam int unsigned CW =
        (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit NO_GAP = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    typedef enum logic [1:0] {HEAD, DATA, TAIL} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    idx_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [47:0]   shadow_q, shadow_d;
    logic [7:0]    dato_q, dato_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          hora_ok;
    logic          xfer;
    logic          gap_end;

    // every character of the requested time must be an ASCII digit
    always_comb begin
        hora_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (hora[8*k +: 8] < 8'h30 || hora[8*k +: 8] > 8'h39)
                hora_ok = 1'b0;
        end
    end

    assign xfer    = (state_q == SEND) && tx.tx_ready;
    assign gap_end = NO_GAP ? xfer
                   : (state_q == GAP) && (cnt_q == CNT_ONE);

    // state, byte pointer and output registers
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_q  <= IDLE;
            phase_q  <= HEAD;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            dato_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dato_q   <= dato_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // frame sequencing: offer, wait for transfer, idle the gap
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && hora_ok) state_d = SEND;
            SEND: begin
                if (xfer) begin
                    if (!NO_GAP)
                        state_d = GAP;
                    else if (phase_q == TAIL)
                        state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_end)
                    state_d = (phase_q == TAIL) ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // next byte, gap count and status pulses
    always_comb begin
        phase_d  = phase_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dato_d   = dato_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        idx_nxt  = idx_q + 3'd1;

        if (state_q == IDLE) begin
            idx_d = '0;
            if (start) begin
                if (hora_ok) begin
                    shadow_d = hora;
                    dato_d   = MARK;
                    phase_d  = HEAD;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (xfer)
            cnt_d = GAP_LOAD;
        else if (state_q == GAP)
            cnt_d = cnt_q - CNT_ONE;

        if (gap_end) begin
            unique case (1'b1)
                (phase_q == HEAD): begin
                    dato_d  = shadow_q[7:0];
                    phase_d = DATA;
                    idx_d   = '0;
                end
                (phase_q == DATA): begin
                    if (idx_q == 3'd5) begin
                        dato_d  = MARK;
                        phase_d = TAIL;
                    end else begin
                        idx_d  = idx_nxt;
                        dato_d = 8'(shadow_q >> {idx_nxt, 3'b000});
                    end
                end
                (phase_q == TAIL): done_d = 1'b1;
                default: phase_d = HEAD;
            endcase
        end
    end

    assign tx.dato     = dato_q;
    assign tx.tx_valid = (state_q == SEND);
    assign busy        = (state_q != IDLE);
    assign DONE        = done_q;
    assign ERR         = err_q;
endmodule

// File: doc/enviar_hora.md
# enviar_hora

Frame transmitter for the clock's time value: on request it serialises a 48-bit ASCII time (HHMMSS, six digit characters) into the byte frame `z` D0 D1 D2 D3 D4 D5 `z`, where `z` is 8'd122. Bytes are paced with a programmable idle gap so a byte-sampling receiver on the far end can take one character per sample. It sits between the time-keeping core and the byte-wide UART transmitter, and sends the format the time-reception path accepts.

## Interface

- MARK, 8'd122, frame delimiter byte sent first and last.
- GAP_CYCLES, 50_000, idle `clk` cycles inserted after every accepted byte (0 allowed).
- clk  in  1  system clock, rising edge.
- init  in  1  asynchronous active-low reset.
- start  in  1  send request; sampled only in IDLE.
- hora  in  48  time to send; byte k = hora[8k+7:8k], k=0 sent first.
- tx_ready  in  1  downstream can accept a byte this cycle.
- dato  out  8  byte offered downstream.
- tx_valid  out  1  `dato` is valid; a transfer occurs on any rising edge with tx_valid && tx_ready.
- busy  out  1  high from the cycle after `start` is accepted until DONE.
- DONE  out  1  one-cycle pulse when a frame has completed.
- ERR  out  1  one-cycle pulse when `start` is rejected for invalid content.

## Operation

- Reset (init=0, asynchronous): state IDLE, dato=0, tx_valid=0, busy=0, DONE=0, ERR=0, gap counter=0, byte index=0, shadow register=0.
- State IDLE:
  - On `start`=1, check all six bytes of `hora` lie in 8'h30..8'h39.
  - If all are valid: latch `hora` into a 48-bit shadow, go to SEND with dato=MARK, and set byte phase to HEAD.
  - If any byte is invalid: pulse ERR for one cycle, stay in IDLE, and emit nothing.
- State SEND:
  - tx_valid=1 and `dato` is held stable until the transfer.
  - On transfer, go to GAP. tx_valid falls on the same edge.
- State GAP:
  - tx_valid=0 for GAP_CYCLES cycles. With GAP_CYCLES=0 this is skipped and the next byte is offered the cycle after the transfer.
  - After HEAD, offer shadow[7:0].
  - After data byte k<5, offer byte k+1.
  - After byte 5, offer MARK as TAIL.
  - After TAIL, go to IDLE with DONE=1 for one cycle.
- Phase sequence per frame: HEAD, D0..D5, TAIL, for 8 bytes total.
- The shadow register decouples the frame from `hora`. Changes on `hora` during a frame do not affect the bytes sent.
- `start` is ignored when not in IDLE. A `start` that is held high is re-sampled in the IDLE cycle after DONE and begins a new frame.
- A `start` in the same cycle as the DONE pulse is not accepted. The state is not IDLE until that edge completes.
- Gap counter width is clog2(GAP_CYCLES+1). It saturates at reset, with no wrap.
- Byte index is 3 bits, counts 0..5, and is cleared in IDLE.

## Timing

- `start` high at edge N in IDLE gives tx_valid=1 and dato=MARK from edge N (registered outputs visible after N). busy=1 from N.
- Throughput with tx_ready held high: each byte occupies 1 valid cycle plus GAP_CYCLES idle cycles.
- DONE asserts at N + 8·(1+GAP_CYCLES) and lasts 1 cycle. busy falls on the same edge.
- Backpressure: tx_ready low stretches SEND indefinitely. `dato` and tx_valid stay constant, and the gap does not start until the transfer.
- ERR asserts at edge N for one cycle. busy stays 0.
- Reset mid-frame: tx_valid drops immediately, the partial frame is abandoned, and no DONE is produced. After release, the next frame starts at HEAD.
- No combinational path exists from any input to any output.

## Test plan

All scenarios use GAP_CYCLES=2.

- Nominal frame: hora=ASCII "123456" (48'h313233343536, so D0='6'=8'h36), start pulse, tx_ready=1. Expect dato sequence 7A,36,35,34,33,32,31,7A, each followed by exactly 2 idle cycles. DONE pulses 24 cycles after start. busy spans the frame.
- Backpressure: same frame with tx_ready low for 5 cycles while D2 is offered. Expect dato=8'h34 held stable for the stall with no byte dropped or duplicated. DONE arrives 5 cycles later than nominal.
- Invalid content: hora byte 3 = 8'h7A, start pulse. Expect ERR for 1 cycle and tx_valid never set. busy=0 and DONE=0.
- Input change mid-frame: start with "000000", then switch hora to "999999" after D0 is sent. Expect all data bytes to be 8'h30.
- Reset mid-frame: deassert init during D3 valid. Expect tx_valid=0, busy=0 and dato=0 asynchronously. A new start after release sends a full frame beginning with 7A.
- Held start and GAP_CYCLES=0 build: with start tied high, expect back-to-back frames of 8 consecutive valid cycles each. Each DONE is followed by 1 IDLE cycle, and a new frame begins on the next edge.
